// File: rtl/fpu_issue_pkg.sv
// Shared types and defaults for the multiply/divide issue controller.
package fpu_issue_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StDone
  } state_e;

  typedef struct packed {
    logic [63:0] fpa;
    logic [63:0] fpb;
    logic        db;
    logic        fdiv;
    logic [1:0]  rm;
  } req_t;

  localparam int unsigned DefDepth  = 4;
  localparam int unsigned DefDivLat = 21;
  localparam int unsigned DefMulLat = 6;
  localparam int unsigned DefClrCyc = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO with registered full/empty flags; head entry is presented combinationally.
module fpu_req_fifo
  import fpu_issue_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  req_t wdata,
  input  logic pop,
  output req_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_t          mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  // Push is refused whenever the pre-edge count says full, even if a pop frees a slot.
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  assign rdata = mem[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/fpu_mul_div_issue.sv
// Sequences buffered mul/div requests into the FP unit: clear pulse, fixed latency, result capture.
module fpu_mul_div_issue
  import fpu_issue_pkg::*;
#(
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned DIV_LAT = DefDivLat,
  parameter int unsigned MUL_LAT = DefMulLat,
  parameter int unsigned CLR_CYC = DefClrCyc
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_fpa,
  input  logic [63:0] req_fpb,
  input  logic        req_db,
  input  logic        req_fdiv,
  input  logic [1:0]  req_rm,
  output logic        unit_rst_n,
  output logic [63:0] unit_fpa,
  output logic [63:0] unit_fpb,
  output logic        unit_db,
  output logic        unit_fdiv,
  output logic        unit_normal,
  output logic        unit_sub,
  output logic [1:0]  unit_rm,
  input  logic [63:0] unit_fp,
  input  logic [4:0]  unit_ieee,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_fp,
  output logic [4:0]  rsp_ieee,
  output logic        rsp_fdiv,
  output logic        busy
);

  localparam int unsigned LatW = $clog2(max_u(DIV_LAT, MUL_LAT) + 1);
  localparam int unsigned ClrW = $clog2(CLR_CYC + 1);

  state_e          state_q;
  logic [ClrW-1:0] clr_cnt_q;
  logic [LatW-1:0] lat_cnt_q;
  req_t            op_q;
  logic            clr_n_q;
  logic            rsp_valid_q;
  logic [63:0]     rsp_fp_q;
  logic [4:0]      rsp_ieee_q;
  logic            rsp_fdiv_q;

  req_t fifo_wdata, fifo_head;
  logic fifo_full, fifo_empty;
  logic start;

  assign fifo_wdata = '{fpa: req_fpa, fpb: req_fpb, db: req_db, fdiv: req_fdiv, rm: req_rm};

  // A slot being drained this very edge counts as free, so back-to-back ops lose no cycle.
  assign start = (state_q == StIdle) && !fifo_empty && (!rsp_valid_q || rsp_ready);

  fpu_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (req_valid),
    .wdata(fifo_wdata),
    .pop  (start),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      clr_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      op_q        <= '0;
      clr_n_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_fp_q    <= '0;
      rsp_ieee_q  <= '0;
      rsp_fdiv_q  <= 1'b0;
    end else begin
      if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StClear;
            op_q      <= fifo_head;
            clr_n_q   <= 1'b0;
            clr_cnt_q <= ClrW'(CLR_CYC);
          end
        end
        StClear: begin
          if (clr_cnt_q == ClrW'(1)) begin
            state_q   <= StRun;
            clr_n_q   <= 1'b1;
            lat_cnt_q <= op_q.fdiv ? LatW'(DIV_LAT) : LatW'(MUL_LAT);
          end else begin
            clr_cnt_q <= clr_cnt_q - 1'b1;
          end
        end
        StRun: begin
          if (lat_cnt_q == LatW'(1)) begin
            state_q <= StDone;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        StDone: begin
          rsp_fp_q    <= unit_fp;
          rsp_ieee_q  <= unit_ieee;
          rsp_fdiv_q  <= op_q.fdiv;
          rsp_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = !fifo_full;
  assign unit_rst_n  = rst_n & clr_n_q;
  assign unit_fpa    = op_q.fpa;
  assign unit_fpb    = op_q.fpb;
  assign unit_db     = op_q.db;
  assign unit_fdiv   = op_q.fdiv;
  assign unit_rm     = op_q.rm;
  assign unit_normal = 1'b1;
  assign unit_sub    = 1'b0;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_fp      = rsp_fp_q;
  assign rsp_ieee    = rsp_ieee_q;
  assign rsp_fdiv    = rsp_fdiv_q;
  assign busy        = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_fpu_mul_div_issue.sv
// Bench for fpu_mul_div_issue: fake FP unit valid only at the exact latency, queue scoreboard.
module tb_fpu_mul_div_issue;

  localparam int DEPTH   = 4;
  localparam int DIV_LAT = 21;
  localparam int MUL_LAT = 6;
  localparam int CLR_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [63:0] req_fpa, req_fpb;
  logic        req_db, req_fdiv;
  logic [1:0]  req_rm;
  logic        unit_rst_n;
  logic [63:0] unit_fpa, unit_fpb;
  logic        unit_db, unit_fdiv, unit_normal, unit_sub;
  logic [1:0]  unit_rm;
  logic [63:0] unit_fp;
  logic [4:0]  unit_ieee;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_fp;
  logic [4:0]  rsp_ieee;
  logic        rsp_fdiv;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_mul_div_issue #(
    .DEPTH  (DEPTH),
    .DIV_LAT(DIV_LAT),
    .MUL_LAT(MUL_LAT),
    .CLR_CYC(CLR_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fpa    (req_fpa),
    .req_fpb    (req_fpb),
    .req_db     (req_db),
    .req_fdiv   (req_fdiv),
    .req_rm     (req_rm),
    .unit_rst_n (unit_rst_n),
    .unit_fpa   (unit_fpa),
    .unit_fpb   (unit_fpb),
    .unit_db    (unit_db),
    .unit_fdiv  (unit_fdiv),
    .unit_normal(unit_normal),
    .unit_sub   (unit_sub),
    .unit_rm    (unit_rm),
    .unit_fp    (unit_fp),
    .unit_ieee  (unit_ieee),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_fp     (rsp_fp),
    .rsp_ieee   (rsp_ieee),
    .rsp_fdiv   (rsp_fdiv),
    .busy       (busy)
  );

  // Unit behaviour: doubles use real arithmetic, other ops a mixing function. Result {flags, fp}.
  function automatic logic [68:0] unit_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic db, input logic fdiv,
                                             input logic [1:0] rm);
    real ra, rb;
    logic [63:0] r;
    logic [4:0]  f;
    if (db) begin
      ra = $bitstoreal(a);
      rb = $bitstoreal(b);
      r  = fdiv ? $realtobits(ra / rb) : $realtobits(ra * rb);
      f  = (fdiv && rb == 0.0 && ra != 0.0) ? 5'b01000 : 5'b00000;
    end else begin
      r = fdiv ? ((a ^ {b[31:0], b[63:32]}) + {62'd0, rm}) : ((a + b) ^ 64'h5555_0000_AAAA_0000);
      f = r[4:0] ^ {fdiv, db, rm, 1'b1};
    end
    return {f, r};
  endfunction

  // Fake unit: cycles since clear release; output is corrupted except at the exact latency.
  int run_cnt = 0;
  always @(posedge clk) begin
    if (unit_rst_n !== 1'b1) run_cnt <= 0;
    else run_cnt <= run_cnt + 1;
  end

  logic [68:0] um;
  always_comb begin
    um = unit_model(unit_fpa, unit_fpb, unit_db, unit_fdiv, unit_rm);
    if (run_cnt != (unit_fdiv ? DIV_LAT : MUL_LAT)) um = ~um;
  end
  assign unit_fp   = um[63:0];
  assign unit_ieee = um[68:64];

  // Monitors: operand changes allowed only at the edge that drops the clear; clear-low run length.
  int          stab_err = 0;
  int          low_run = 0;
  int          last_low = 0;
  logic [63:0] prev_a, prev_b;
  logic        prev_urst;
  bit          prev_ok = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && prev_ok &&
        (unit_fpa !== prev_a || unit_fpb !== prev_b) &&
        !(prev_urst === 1'b1 && unit_rst_n === 1'b0))
      stab_err++;
    prev_a    = unit_fpa;
    prev_b    = unit_fpb;
    prev_urst = unit_rst_n;
    prev_ok   = (rst_n === 1'b1);
    if (rst_n !== 1'b1) begin
      low_run = 0;
    end else if (unit_rst_n === 1'b0) begin
      low_run++;
    end else if (low_run != 0) begin
      last_low = low_run;
      low_run  = 0;
    end
  end

  logic [68:0] exp_q[$];
  logic        exp_fdiv_q[$];

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called between a posedge and the following negedge; returns at a negedge.
  task automatic wait_rsp(input string tag, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk({tag, "_timeout"}, {68'd0, rsp_valid}, 69'd1);
  endtask

  task automatic check_head(input string tag);
    logic [68:0] e;
    logic        f;
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_rsp"}, {68'd0, rsp_valid}, 69'd0);
    end else begin
      e = exp_q.pop_front();
      f = exp_fdiv_q.pop_front();
      chk({tag, "_fp"}, {5'd0, rsp_fp}, {5'd0, e[63:0]});
      chk({tag, "_ieee"}, {64'd0, rsp_ieee}, {64'd0, e[68:64]});
      chk({tag, "_fdiv"}, {68'd0, rsp_fdiv}, {68'd0, f});
    end
  endtask

  // Called at a negedge with rsp_valid high; returns just after the next posedge.
  task automatic consume(input string tag);
    check_head(tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic db,
                      input logic fdiv, input logic [1:0] rm, output int acc);
    bit ok;
    ok = 0;
    req_fpa = a; req_fpb = b; req_db = db; req_fdiv = fdiv; req_rm = rm;
    req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", {68'd0, req_ready}, 69'd1);
    acc = cyc + 1;
    exp_q.push_back(unit_model(a, b, db, fdiv, rm));
    exp_fdiv_q.push_back(fdiv);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, c1, c2, sent, recv;
    bit hs_req, hs_rsp;
    logic [63:0] ra, rb;
    logic rdb, rdv;
    logic [1:0] rrm;

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_fpa = '0; req_fpb = '0; req_db = 1'b0; req_fdiv = 1'b0; req_rm = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {68'd0, req_ready}, 69'd1);
    chk("rst_unit_rst_n", {68'd0, unit_rst_n}, 69'd0);
    chk("rst_rsp_valid", {68'd0, rsp_valid}, 69'd0);
    chk("rst_busy", {68'd0, busy}, 69'd0);
    chk("rst_unit_fpa", {5'd0, unit_fpa}, 69'd0);
    chk("rst_unit_normal_sub", {67'd0, unit_normal, unit_sub}, 69'b10);
    chk("rst_rsp_fp", {5'd0, rsp_fp}, 69'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single divide 1.5 / 0.5
    send(64'h3FF8000000000000, 64'h3FE0000000000000, 1'b1, 1'b1, 2'b01, acc);
    wait_rsp("div", 200);
    chk("div_latency", 69'(cyc - acc), 69'(CLR_CYC + DIV_LAT + 2));
    chk("div_fp_const", {5'd0, rsp_fp}, {5'd0, 64'h4008000000000000});
    consume("div");

    // Single multiply 2.0 * 3.0
    send(64'h4000000000000000, 64'h4008000000000000, 1'b1, 1'b0, 2'b00, acc);
    wait_rsp("mul", 200);
    chk("mul_latency", 69'(cyc - acc), 69'(CLR_CYC + MUL_LAT + 2));
    chk("mul_fp_const", {5'd0, rsp_fp}, {5'd0, 64'h4018000000000000});
    chk("mul_clear_cycles", 69'(last_low), 69'(CLR_CYC));
    consume("mul");

    // Divide by zero
    send(64'h3FF0000000000000, 64'h0000000000000000, 1'b1, 1'b1, 2'b00, acc);
    wait_rsp("dz", 200);
    chk("dz_fp_const", {5'd0, rsp_fp}, {5'd0, 64'h7FF0000000000000});
    chk("dz_flag", {68'd0, rsp_ieee[3]}, 69'd1);
    consume("dz");

    // Back-to-back throughput with rsp_ready held high
    rsp_ready = 1'b1;
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 2'($urandom), acc);
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 2'($urandom), acc);
    wait_rsp("tp1", 200);
    c1 = cyc;
    check_head("tp1");
    @(posedge clk); #1;
    wait_rsp("tp2", 200);
    c2 = cyc;
    check_head("tp2");
    chk("throughput", 69'(c2 - c1), 69'(CLR_CYC + MUL_LAT + 2));
    @(posedge clk); #1 rsp_ready = 1'b0;

    // Fill: one op in flight plus DEPTH queued, response held off
    for (int i = 0; i < DEPTH + 1; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'($urandom), 2'($urandom), acc);
    @(negedge clk);
    chk("fill_req_ready", {68'd0, req_ready}, 69'd0);
    chk("fill_busy", {68'd0, busy}, 69'd1);
    @(posedge clk); #1;
    req_fpa = 64'hBAD; req_valid = 1'b1;
    repeat (40) @(negedge clk);
    chk("fill_rsp_held", {68'd0, rsp_valid}, 69'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      wait_rsp("drain", 200);
      consume("drain");
    end
    repeat (60) @(negedge clk);
    chk("drain_no_extra", {68'd0, rsp_valid}, 69'd0);
    @(posedge clk); #1;

    // Randomised traffic
    sent = 0; recv = 0;
    for (int c = 0; c < 6000 && recv < 40; c++) begin
      @(negedge clk);
      hs_req = req_valid && req_ready;
      hs_rsp = rsp_valid && rsp_ready;
      if (hs_rsp) begin
        check_head("rand");
        recv++;
      end
      if (hs_req) begin
        exp_q.push_back(unit_model(req_fpa, req_fpb, req_db, req_fdiv, req_rm));
        exp_fdiv_q.push_back(req_fdiv);
        sent++;
      end
      @(posedge clk); #1;
      if (hs_req) req_valid = 1'b0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid && sent < 40 && $urandom_range(0, 2) == 0) begin
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        rdb = 1'b0; rdv = 1'($urandom); rrm = 2'($urandom);
        req_fpa = ra; req_fpb = rb; req_db = rdb; req_fdiv = rdv; req_rm = rrm;
        req_valid = 1'b1;
      end
    end
    chk("rand_recv_count", 69'(recv), 69'd40);
    chk("rand_queue_empty", 69'(exp_q.size()), 69'd0);
    rsp_ready = 1'b0; req_valid = 1'b0;

    // Reset in the middle of a divide
    send(64'h3FF8000000000000, 64'h3FE0000000000000, 1'b1, 1'b1, 2'b01, acc);
    repeat (CLR_CYC + 6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_unit_rst_n", {68'd0, unit_rst_n}, 69'd0);
    chk("midrst_busy_valid", {67'd0, busy, rsp_valid}, 69'd0);
    chk("midrst_req_ready", {68'd0, req_ready}, 69'd1);
    chk("midrst_unit_ops", {4'd0, unit_fdiv, unit_fpa}, 69'd0);
    exp_q.delete();
    exp_fdiv_q.delete();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(64'h4000000000000000, 64'h4008000000000000, 1'b1, 1'b0, 2'b10, acc);
    wait_rsp("post_rst", 200);
    chk("post_rst_latency", 69'(cyc - acc), 69'(CLR_CYC + MUL_LAT + 2));
    consume("post_rst");

    chk("operand_stability", 69'(stab_err), 69'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
